// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_decode_arbiter_if #(
    parameter int BITS = 3
);
    localparam int N = 1 << BITS;

    logic [N-1:0]    req;
    logic            gnt_valid;
    logic [BITS-1:0] gnt_idx;
    logic [N-1:0]    gnt_oh;
    logic            preempt;

    modport master (
        output req,
        input  gnt_valid, gnt_idx, gnt_oh, preempt
    );

    modport slave (
        input  req,
        output gnt_valid, gnt_idx, gnt_oh, preempt
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter with binary owner index, one-hot decode and hold-limit preemption
module rr_decode_arbiter #(
    parameter int BITS     = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_decode_arbiter_if.slave arb
);
    localparam int N    = 1 << BITS;
    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

    if (BITS < 1) begin : g_bits_check
        $error("rr_decode_arbiter: BITS must be at least 1");
    end
    if (HOLD_MAX < 1) begin : g_hold_check
        $error("rr_decode_arbiter: HOLD_MAX must be at least 1");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] idx_q, idx_d;
    logic [BITS-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            preempt_q, preempt_d;

    logic [N-1:0]    owner_oh;
    logic [N-1:0]    cand;
    logic [BITS-1:0] winner;
    logic            found;
    logic            expired;

    assign owner_oh = N'(1) << idx_q;
    assign expired  = (hold_q == HOLD_LAST);

    // While granted, ptr always equals owner+1, so masking the owner yields the "others" search.
    assign cand = (state_q == GRANT) ? (arb.req & ~owner_oh) : arb.req;

    always_comb begin : search
        logic [BITS-1:0] probe;
        winner = '0;
        found  = 1'b0;
        probe  = ptr_q;
        for (int i = 0; i < N; i++) begin
            probe = ptr_q + BITS'(i);
            if (!found && cand[probe]) begin
                winner = probe;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    idx_d   = winner;
                    ptr_d   = winner + BITS'(1);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!arb.req[idx_q]) begin
                    // Release takes priority over a coincident expiry.
                    if (found) begin
                        idx_d  = winner;
                        ptr_d  = winner + BITS'(1);
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (expired) begin
                    hold_d = '0;
                    if (found) begin
                        idx_d     = winner;
                        ptr_d     = winner + BITS'(1);
                        preempt_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign arb.gnt_valid = valid_q;
    assign arb.gnt_idx   = idx_q;
    assign arb.preempt   = preempt_q;
    assign arb.gnt_oh    = valid_q ? owner_oh : '0;

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(arb.gnt_oh));

    a_req_backed: assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> ($past(arb.req[idx_q]) || (idx_q != $past(idx_q)) || !$past(valid_q)));

    a_preempt_owner: assert property (@(posedge clk) disable iff (!rst_n)
        preempt_q |-> $past(valid_q));
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - scoreboard bench for rr_decode_arbiter (BITS=3/HOLD_MAX=4 and BITS=1/HOLD_MAX=1)
module tb_rr_decode_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rr_decode_arbiter_if #(.BITS(3)) ifa ();
    rr_decode_arbiter_if #(.BITS(1)) ifb ();

    rr_decode_arbiter #(.BITS(3), .HOLD_MAX(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifa.slave)
    );

    rr_decode_arbiter #(.BITS(1), .HOLD_MAX(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifb.slave)
    );

    typedef struct {
        logic       v;
        logic [2:0] idx;
        logic       pre;
        string      tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic [7:0] r, input logic v, input logic [2:0] idx,
                          input logic pre, input string tag);
        @(negedge clk);
        ifa.req = r;
        qa.push_back('{v, idx, pre, tag});
    endtask

    task automatic step_b(input logic [1:0] r, input logic v, input logic [2:0] idx,
                          input logic pre, input string tag);
        @(negedge clk);
        ifb.req = r;
        qb.push_back('{v, idx, pre, tag});
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk({ea.tag, " valid"},   32'(ifa.gnt_valid), 32'(ea.v));
            chk({ea.tag, " oh"},      32'(ifa.gnt_oh),    ea.v ? (32'd1 << ea.idx) : 32'd0);
            chk({ea.tag, " preempt"}, 32'(ifa.preempt),   32'(ea.pre));
            if (ea.v) chk({ea.tag, " idx"}, 32'(ifa.gnt_idx), 32'(ea.idx));
        end
    end

    always @(posedge clk) begin
        #1;
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk({eb.tag, " valid"},   32'(ifb.gnt_valid), 32'(eb.v));
            chk({eb.tag, " oh"},      32'(ifb.gnt_oh),    eb.v ? (32'd1 << eb.idx) : 32'd0);
            chk({eb.tag, " preempt"}, 32'(ifb.preempt),   32'(eb.pre));
            if (eb.v) chk({eb.tag, " idx"}, 32'(ifb.gnt_idx), 32'(eb.idx));
        end
    end

    initial begin
        ifa.req = '0;
        ifb.req = '0;
        repeat (2) @(negedge clk);
        chk("reset valid",   32'(ifa.gnt_valid), 32'd0);
        chk("reset oh",      32'(ifa.gnt_oh),    32'd0);
        chk("reset preempt", 32'(ifa.preempt),   32'd0);
        chk("reset idx",     32'(ifa.gnt_idx),   32'd0);
        rst_n = 1'b1;

        // single requester, then drop to idle
        step_a(8'h10, 1'b1, 3'd4, 1'b0, "single_grant");
        step_a(8'h00, 1'b0, 3'd0, 1'b0, "single_release");

        // lone holder: hold expiry with no contender keeps the grant
        for (int c = 0; c < 20; c++) step_a(8'h08, 1'b1, 3'd3, 1'b0, "lone_holder");
        step_a(8'h00, 1'b0, 3'd0, 1'b0, "lone_release");

        // release handoff 2 -> 5 without a bubble
        step_a(8'h04, 1'b1, 3'd2, 1'b0, "handoff_grant");
        step_a(8'h24, 1'b1, 3'd2, 1'b0, "handoff_hold");
        step_a(8'h20, 1'b1, 3'd5, 1'b0, "handoff_switch");
        step_a(8'h00, 1'b0, 3'd0, 1'b0, "handoff_idle");

        // release coinciding with hold expiry: switch without preempt
        for (int c = 0; c < 4; c++) step_a(8'h04, 1'b1, 3'd2, 1'b0, "coincide_hold");
        step_a(8'h40, 1'b1, 3'd6, 1'b0, "coincide_switch");
        step_a(8'h00, 1'b0, 3'd0, 1'b0, "coincide_idle");

        // async reset in the middle of a grant
        step_a(8'hFF, 1'b1, 3'd7, 1'b0, "pre_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async valid",   32'(ifa.gnt_valid), 32'd0);
        chk("async oh",      32'(ifa.gnt_oh),    32'd0);
        chk("async preempt", 32'(ifa.preempt),   32'd0);
        chk("async idx",     32'(ifa.gnt_idx),   32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("held reset valid", 32'(ifa.gnt_valid), 32'd0);
        rst_n = 1'b1;
        qa.push_back('{1'b1, 3'd0, 1'b0, "rotate"});

        // full contention: each owner for 4 cycles, wrap 7 -> 0
        for (int c = 1; c < 36; c++)
            step_a(8'hFF, 1'b1, 3'((c / 4) % 8), (c % 4) == 0, "rotate");
        step_a(8'h00, 1'b0, 3'd0, 1'b0, "rotate_idle");

        // BITS=1, HOLD_MAX=1: strict alternation
        step_b(2'b11, 1'b1, 3'd0, 1'b0, "alt0");
        step_b(2'b11, 1'b1, 3'd1, 1'b1, "alt1");
        step_b(2'b11, 1'b1, 3'd0, 1'b1, "alt2");
        step_b(2'b00, 1'b0, 3'd0, 1'b0, "alt_idle");

        for (int i = 0; i < 20 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
        chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
